id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised, handshaked instruction-decode stage for the RV32IF pipeline, the successor to the combinational-output Id_stage. It holds the integer register file with write-back bypass and decodes opcode, immediate and control fields. It detects load-use hazards and stalls on them. Results are registered into an ID/EX output register with valid/ready flow control and a flush input for branch or jump redirects.

Parameters:
XLEN, 32, data/PC width
NREGS, 32, integer register count (power of 2); register index width is RW = log2(NREGS)
FWD_WB, 1, 1 = forward same-cycle write-back data onto register reads

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
flush  in  1  kill in-flight and accepted-this-cycle instruction
wb_en  in  1  register write-back enable
wb_rd  in  RW  write-back destination
wb_data  in  XLEN  write-back data
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts ID/EX contents
out_pc, out_link  out  XLEN  PC; PC+4 (modulo 2^XLEN)
out_rs1_data, out_rs2_data, out_imm  out  XLEN  operands; sign-extended immediate
out_rd  out  RW  destination register
out_opcode/out_funct3/out_funct7  out  7/3/7  raw fields
out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal  out  1 each  control
hazard_cnt  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0, async): all outputs and the ID/EX register are 0; register file is cleared to 0; hazard_cnt=0.
- Register file: x0 reads 0 and ignores writes. Write occurs on posedge when wb_en && wb_rd!=0. Read is combinational. With FWD_WB=1, a read where rsN==wb_rd!=0 && wb_en returns wb_data.
- Decode: the immediate follows the RV32 I/S/B/U/J format and is sign-extended to XLEN. Any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} sets out_illegal=1 and forces reg_write, mem_write, branch, jal and jalr to 0. out_reg_write=0 when rd=0.
- Hazard: hz=1 when out_valid && out_mem_read && out_rd!=0 && (out_rd==rs1 || (out_rd==rs2 && opcode uses rs2: BRANCH/STORE/OP)).
- in_ready = (!out_valid || out_ready) && !hz && !flush.
- Accept (in_valid && in_ready): the ID/EX register loads the decoded fields on the next edge. Latency is 1 cycle.
- Output handshake: out_valid && !out_ready holds all out_* stable. If out_ready=1 and no accept occurs, out_valid goes to 0 next cycle.
- hz && out_ready: a bubble is inserted (out_valid=0) and the instruction stays pending upstream. hazard_cnt increments once per hz cycle and saturates at 0xFFFF.
- flush=1: out_valid=0 next cycle and no accept occurs that cycle. Flush has priority over hz and over write-back (write-back still commits).
- Simultaneous WB write and read of the same register: the forwarded value is used when FWD_WB=1; otherwise the old value is read.
- Reset asserted mid-operation: the pending instruction is lost and upstream must replay it.

Optional Feature:
ID_FREG_EN: when defined, the block adds a 32xXLEN FP register file, ports fwb_en/fwb_rd/fwb_data, out_frs1_data/out_frs2_data/out_frs3_data and out_fp. It decodes OP-FP, FLW, FSW and FMADD-family opcodes, which are then not illegal, and applies the same bypass rule without the x0 exception. When undefined, these opcodes set out_illegal=1 and none of these ports exist.

Decomposition:
- Package rv_pkg: opcode constants (OPC_LUI…OPC_OPFP), the imm-format enum, and a typedef for the ID/EX bundle struct.
- One sub-module, id_regfile (parametrised NREGS/XLEN, 2 read ports, 1 write port, optional bypass), is instantiated once for the integer file and once more under ID_FREG_EN with a 3rd read port.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release, then issue ADDI x10,x0,5 (0x00500513) -> out_valid=1 one cycle later with out_imm=5, out_rd=10, out_reg_write=1, out_rs1_data=0.
- Bypass: wb_en=1, wb_rd=6, wb_data=0x1234 in the same cycle as ADD x5,x6,x7 -> out_rs1_data=0x1234. Repeat with wb_rd=0 -> out_rs1_data=0.
- Load-use: LW x5,25(x4), then ADD x6,x5,x1 with out_ready=1 -> in_ready=0 for one cycle, a single bubble is inserted, ADD issues the next cycle, hazard_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with BEQ x3,x4,16 in ID/EX -> outputs stable, in_ready=0, out_imm=16, out_branch=1.
- Flush: JAL x1,16 at pc=0x100 accepted, then flush=1 while ADDI is valid -> out_valid=0 the next cycle, ADDI is not consumed. For the JAL: out_link=0x104, out_imm=16.
- Illegal/FP: instruction 0x00000053 (OP-FP) -> out_illegal=1 without ID_FREG_EN; with ID_FREG_EN, out_illegal=0 and out_fp=1.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: RV32IF opcode constants, immediate formats, the ID/EX control bundle and the immediate generator.
package rv_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;
    localparam logic [6:0] OPC_OPFP   = 7'b1010011;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic reg_write, mem_read, mem_write, branch, jal, jalr, illegal;
    } idex_ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
        return f == IMM_I ? {{20{i[31]}}, i[31:20]} :
               f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
               f == IMM_U ? {i[31:12], 12'b0} :
               f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
    endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID input handshake and ID/EX output bundle; slave is the decode stage.
interface id_stage_pipe_if #(parameter int XLEN = 32, parameter int RW = 5);
    logic in_valid, in_ready;
    logic [31:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_link, out_rs1_data, out_rs2_data, out_imm;
    logic [RW-1:0] out_rd;
    logic [6:0] out_opcode, out_funct7;
    logic [2:0] out_funct3;
    logic out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal;
`ifdef ID_FREG_EN
    logic [XLEN-1:0] out_frs1_data, out_frs2_data, out_frs3_data;
    logic out_fp;
`endif

    modport slave (
`ifdef ID_FREG_EN
        output out_frs1_data, out_frs2_data, out_frs3_data, out_fp,
`endif
        input in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_link, out_rs1_data, out_rs2_data, out_imm, out_rd,
        output out_opcode, out_funct3, out_funct7,
        output out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal
    );

    modport master (
`ifdef ID_FREG_EN
        input out_frs1_data, out_frs2_data, out_frs3_data, out_fp,
`endif
        output in_valid, in_instr, in_pc, out_ready,
        input in_ready, out_valid, out_pc, out_link, out_rs1_data, out_rs2_data, out_imm, out_rd,
        input out_opcode, out_funct3, out_funct7,
        input out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal
    );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, NRD combinational read ports, one write port and
// optional write-through bypass; ZERO0 hardwires entry 0 to zero and drops writes to it.
module id_regfile #(
    parameter int NREGS = 32,
    parameter int XLEN = 32,
    parameter int NRD = 2,
    parameter bit FWD = 1'b1,
    parameter bit ZERO0 = 1'b1,
    localparam int RW = $clog2(NREGS)
) (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic [RW-1:0] wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RW-1:0] ra [NRD],
    output logic [XLEN-1:0] rdata [NRD]
);
    logic [XLEN-1:0] mem [NREGS];
    logic wr;

    assign wr = we && (!ZERO0 || wa != '0);

    always_ff @(posedge clk or negedge rst)
        if (!rst) mem <= '{default: '0};
        else if (wr) mem[wa] <= wd;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rdata[i] = FWD && wr && ra[i] == wa ? wd : mem[ra[i]];
    end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32IF decode stage with integer register file, load-use stall and handshaked ID/EX register.
// Define ID_FREG_EN to add the FP register file and decode FLW/FSW/OP-FP/FMADD-family opcodes.
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter bit FWD_WB = 1'b1,
    localparam int RW = $clog2(NREGS)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
`ifdef ID_FREG_EN
    input  logic fwb_en,
    input  logic [4:0] fwb_rd,
    input  logic [XLEN-1:0] fwb_data,
`endif
    output logic [15:0] hazard_cnt,
    id_stage_pipe_if.slave io
);
    logic [31:0] instr;
    logic [6:0] opc;
    logic [RW-1:0] rs1, rs2, rd, rd_q;
    logic int_ok, fp_ok, use_rs2, hz, accept, v_q;
    imm_fmt_e fmt;
    idex_ctrl_t d, q;
    logic [RW-1:0] ra [2];
    logic [XLEN-1:0] rdata [2];
    logic [XLEN-1:0] pc_q, link_q, a_q, b_q, imm_q;

    assign instr = io.in_instr;
    assign opc = instr[6:0];
    assign rd = instr[7 +: RW];
    assign rs1 = instr[15 +: RW];
    assign rs2 = instr[20 +: RW];
    assign ra[0] = rs1;
    assign ra[1] = rs2;
    assign int_ok = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
`ifdef ID_FREG_EN
    assign fp_ok = opc inside {OPC_FLW, OPC_FSW, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD, OPC_OPFP};
`else
    assign fp_ok = 1'b0;
`endif
    assign use_rs2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    assign fmt = opc inside {OPC_LUI, OPC_AUIPC} ? IMM_U :
                 opc == OPC_JAL ? IMM_J :
                 opc == OPC_BRANCH ? IMM_B :
                 opc inside {OPC_STORE, OPC_FSW} ? IMM_S :
                 opc inside {OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FLW} ? IMM_I : IMM_R;

    // Control bits only fire on legal integer/FP opcodes, so illegal words decode to no side effects.
    always_comb begin
        d.opcode = opc;
        d.funct3 = instr[14:12];
        d.funct7 = instr[31:25];
        d.reg_write = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP} && rd != '0;
        d.mem_read = opc == OPC_LOAD || (fp_ok && opc == OPC_FLW);
        d.mem_write = opc == OPC_STORE || (fp_ok && opc == OPC_FSW);
        d.branch = opc == OPC_BRANCH;
        d.jal = opc == OPC_JAL;
        d.jalr = opc == OPC_JALR;
        d.illegal = !(int_ok || fp_ok);
    end

    id_regfile #(.NREGS(NREGS), .XLEN(XLEN), .NRD(2), .FWD(FWD_WB), .ZERO0(1'b1)) u_xrf (
        .clk, .rst, .we(wb_en), .wa(wb_rd), .wd(wb_data), .ra, .rdata
    );

    assign hz = v_q && q.mem_read && rd_q != '0 && (rd_q == rs1 || (rd_q == rs2 && use_rs2));
    assign io.in_ready = (!v_q || io.out_ready) && !hz && !flush;
    assign accept = io.in_valid && io.in_ready;

`ifdef ID_FREG_EN
    logic [4:0] fra [3];
    logic [XLEN-1:0] fdata [3];
    logic [XLEN-1:0] f1_q, f2_q, f3_q;
    logic fp_q;
    assign fra[0] = instr[19:15];
    assign fra[1] = instr[24:20];
    assign fra[2] = instr[31:27];
    id_regfile #(.NREGS(32), .XLEN(XLEN), .NRD(3), .FWD(FWD_WB), .ZERO0(1'b0)) u_frf (
        .clk, .rst, .we(fwb_en), .wa(fwb_rd), .wd(fwb_data), .ra(fra), .rdata(fdata)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            f1_q <= '0;
            f2_q <= '0;
            f3_q <= '0;
            fp_q <= 1'b0;
        end else if (accept) begin
            f1_q <= fdata[0];
            f2_q <= fdata[1];
            f3_q <= fdata[2];
            fp_q <= fp_ok;
        end
    assign io.out_frs1_data = f1_q;
    assign io.out_frs2_data = f2_q;
    assign io.out_frs3_data = f3_q;
    assign io.out_fp = fp_q;
`endif

    // Fields only move on accept, so a stalled or drained entry keeps its last contents.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v_q <= 1'b0;
            q <= '0;
            rd_q <= '0;
            pc_q <= '0;
            link_q <= '0;
            a_q <= '0;
            b_q <= '0;
            imm_q <= '0;
            hazard_cnt <= '0;
        end else begin
            v_q <= accept || (v_q && !io.out_ready && !flush);
            if (hz && hazard_cnt != 16'hFFFF) hazard_cnt <= hazard_cnt + 16'd1;
            if (accept) begin
                q <= d;
                rd_q <= rd;
                pc_q <= io.in_pc;
                link_q <= io.in_pc + XLEN'(4);
                a_q <= rdata[0];
                b_q <= rdata[1];
                imm_q <= XLEN'($signed(imm_gen(instr, fmt)));
            end
        end

    assign io.out_valid = v_q;
    assign io.out_pc = pc_q;
    assign io.out_link = link_q;
    assign io.out_rs1_data = a_q;
    assign io.out_rs2_data = b_q;
    assign io.out_imm = imm_q;
    assign io.out_rd = rd_q;
    assign io.out_opcode = q.opcode;
    assign io.out_funct3 = q.funct3;
    assign io.out_funct7 = q.funct7;
    assign io.out_reg_write = q.reg_write;
    assign io.out_mem_read = q.mem_read;
    assign io.out_mem_write = q.mem_write;
    assign io.out_branch = q.branch;
    assign io.out_jal = q.jal;
    assign io.out_jalr = q.jalr;
    assign io.out_illegal = q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: bench for id_stage_pipe (XLEN=32, NREGS=32, FWD_WB=1).
module tb_id_stage_pipe;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] ADDI10_5 = 32'h00500513;
    localparam logic [31:0] ADD_567  = 32'h007302B3;
    localparam logic [31:0] ADD_507  = 32'h007002B3;
    localparam logic [31:0] LW_5_4   = 32'h01922283;
    localparam logic [31:0] ADD_651  = 32'h00128333;
    localparam logic [31:0] ADD_615  = 32'h00508333;
    localparam logic [31:0] BEQ_3_4  = 32'h00418863;
    localparam logic [31:0] JAL_1_16 = 32'h010000EF;
    localparam logic [31:0] LUI_1    = 32'h123450B7;
    localparam logic [31:0] ADDI_M1  = 32'hFFF00093;
    localparam logic [31:0] OPFP     = 32'h00000053;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic wb_en = 1'b0;
    logic [4:0] wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [15:0] hazard_cnt;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    id_stage_pipe_if #(.XLEN(32), .RW(5)) io ();

`ifdef ID_FREG_EN
    logic fwb_en = 1'b0;
    logic [4:0] fwb_rd = '0;
    logic [31:0] fwb_data = '0;
`endif

    id_stage_pipe #(.XLEN(32), .NREGS(32), .FWD_WB(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .wb_en(wb_en),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
`ifdef ID_FREG_EN
        .fwb_en(fwb_en),
        .fwb_rd(fwb_rd),
        .fwb_data(fwb_data),
`endif
        .hazard_cnt(hazard_cnt),
        .io(io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        io.in_valid = 1'b1;
        io.in_instr = instr;
        io.in_pc = pc;
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.in_instr = NOP;
        io.in_pc = '0;
        io.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(io.out_valid), 0);
        chk("rst_pc", io.out_pc, 0);
        chk("rst_imm", io.out_imm, 0);
        chk("rst_hzcnt", 32'(hazard_cnt), 0);
        rst = 1'b1;

        issue(ADDI10_5, 32'h0);
        tick();
        io.in_valid = 1'b0;
        chk("addi_valid", 32'(io.out_valid), 1);
        chk("addi_imm", io.out_imm, 5);
        chk("addi_rd", 32'(io.out_rd), 10);
        chk("addi_rw", 32'(io.out_reg_write), 1);
        chk("addi_rs1", io.out_rs1_data, 0);
        chk("addi_illegal", 32'(io.out_illegal), 0);
        tick();
        chk("drain_valid", 32'(io.out_valid), 0);

        issue(ADD_567, 32'h4);
        wb_en = 1'b1;
        wb_rd = 5'd6;
        wb_data = 32'h1234;
        tick();
        chk("byp_rs1", io.out_rs1_data, 32'h1234);
        chk("byp_rs2", io.out_rs2_data, 0);
        chk("byp_link", io.out_link, 32'h8);
        issue(ADD_507, 32'h8);
        wb_rd = 5'd0;
        wb_data = 32'hDEAD;
        tick();
        wb_en = 1'b0;
        chk("x0_rs1", io.out_rs1_data, 0);
        issue(ADD_567, 32'hC);
        tick();
        io.in_valid = 1'b0;
        chk("stored_rs1", io.out_rs1_data, 32'h1234);

        issue(LW_5_4, 32'h10);
        tick();
        chk("lw_memrd", 32'(io.out_mem_read), 1);
        chk("lw_imm", io.out_imm, 25);
        issue(ADD_651, 32'h14);
        #1;
        chk("hz_in_ready", 32'(io.in_ready), 0);
        tick();
        chk("bubble_valid", 32'(io.out_valid), 0);
        chk("post_hz_ready", 32'(io.in_ready), 1);
        tick();
        chk("use_valid", 32'(io.out_valid), 1);
        chk("use_pc", io.out_pc, 32'h14);
        chk("use_rd", 32'(io.out_rd), 6);
        chk("hzcnt_1", 32'(hazard_cnt), 1);

        issue(LW_5_4, 32'h18);
        tick();
        issue(ADDI10_5, 32'h1C);
        #1;
        chk("opimm_no_hz", 32'(io.in_ready), 1);
        tick();
        chk("opimm_pc", io.out_pc, 32'h1C);
        chk("hzcnt_still1", 32'(hazard_cnt), 1);

        issue(LW_5_4, 32'h20);
        tick();
        issue(ADD_615, 32'h24);
        #1;
        chk("rs2_hz_ready", 32'(io.in_ready), 0);
        tick();
        chk("rs2_bubble", 32'(io.out_valid), 0);
        tick();
        io.in_valid = 1'b0;
        chk("rs2_use_pc", io.out_pc, 32'h24);
        chk("hzcnt_2", 32'(hazard_cnt), 2);

        issue(BEQ_3_4, 32'h30);
        tick();
        chk("beq_branch", 32'(io.out_branch), 1);
        chk("beq_imm", io.out_imm, 16);
        chk("beq_rw", 32'(io.out_reg_write), 0);
        io.out_ready = 1'b0;
        issue(NOP, 32'h34);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(io.in_ready), 0);
            tick();
            chk("bp_valid", 32'(io.out_valid), 1);
            chk("bp_pc", io.out_pc, 32'h30);
            chk("bp_imm", io.out_imm, 16);
            chk("bp_branch", 32'(io.out_branch), 1);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        tick();
        chk("bp_release", 32'(io.out_valid), 0);

        issue(JAL_1_16, 32'h100);
        tick();
        chk("jal_jal", 32'(io.out_jal), 1);
        chk("jal_link", io.out_link, 32'h104);
        chk("jal_imm", io.out_imm, 16);
        chk("jal_rw", 32'(io.out_reg_write), 1);
        issue(ADDI10_5, 32'h104);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(io.in_ready), 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(io.out_valid), 0);
        tick();
        chk("replay_valid", 32'(io.out_valid), 1);
        chk("replay_pc", io.out_pc, 32'h104);

        issue(LUI_1, 32'h108);
        tick();
        chk("lui_imm", io.out_imm, 32'h12345000);
        issue(ADDI_M1, 32'h10C);
        tick();
        chk("neg_imm", io.out_imm, 32'hFFFFFFFF);
        issue(OPFP, 32'h110);
        tick();
        io.in_valid = 1'b0;
        chk("opfp_rw", 32'(io.out_reg_write), 0);
`ifdef ID_FREG_EN
        chk("opfp_illegal", 32'(io.out_illegal), 0);
        chk("opfp_fp", 32'(io.out_fp), 1);
`else
        chk("opfp_illegal", 32'(io.out_illegal), 1);
`endif

        issue(ADDI10_5, 32'h300);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("amid_valid", 32'(io.out_valid), 0);
        chk("amid_pc", io.out_pc, 0);
        chk("amid_hzcnt", 32'(hazard_cnt), 0);
        rst = 1'b1;
        issue(ADD_567, 32'h400);
        tick();
        io.in_valid = 1'b0;
        chk("rf_cleared", io.out_rs1_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
